// File: rtl/kelly_pkg.sv
// Shared types, sizing constants and helper functions for the Kelly portfolio sizer.
// Optional statistics counters are enabled with KELLY_PORTFOLIO_STATS_EN (see kelly_portfolio.sv).
package kelly_pkg;

    localparam int NUM_STOCKS  = 4;
    localparam int ID_W        = $clog2(NUM_STOCKS);
    localparam int PRICE_W     = 6;
    localparam int NUM_IND     = 3;
    localparam int VOTE_TH     = 2;
    localparam int QTY_W       = 10;
    localparam int CASH_W      = 16;
    localparam int PROFIT_W    = 20;
    localparam int INIT_CASH   = 25000;
    localparam int INIT_SHARES = 100;
    localparam int KP_W        = 7;
    localparam int DIV_W       = QTY_W + KP_W;
    localparam int DIVISOR     = 100;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUY    = 2'd1,
        ACT_SELL   = 2'd2,
        ACT_REJECT = 2'd3
    } act_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIV    = 2'd1,
        S_COMMIT = 2'd2,
        S_VALUE  = 2'd3
    } state_t;

    // Even-odds Kelly fraction in percent: max(0, 2*min(win,100) - 100).
    function automatic logic [KP_W-1:0] kelly_kp(input logic [6:0] win);
        logic [7:0] w2;
        w2 = (win > 7'd100) ? 8'd200 : {win, 1'b0};
        return (w2 > 8'd100) ? KP_W'(w2 - 8'd100) : '0;
    endfunction

    function automatic int unsigned vote_count(input logic [NUM_IND-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_IND; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic act_t vote_side(input logic [NUM_IND-1:0] bv,
                                       input logic [NUM_IND-1:0] sv);
        logic b;
        logic s;
        b = vote_count(bv) >= VOTE_TH;
        s = vote_count(sv) >= VOTE_TH;
        if (b && !s) return ACT_BUY;
        if (s && !b) return ACT_SELL;
        return ACT_HOLD;
    endfunction

endpackage

// File: rtl/kelly_portfolio_if.sv
// Record-in / result-out bundle of the Kelly portfolio sizer.
// Handshake: a record transfers on a clock edge where in_valid && in_ready; out_valid is a one-cycle result pulse.
interface kelly_portfolio_if;
    import kelly_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [ID_W+PRICE_W-1:0]     data_in;
    logic [NUM_IND-1:0]          buy_votes;
    logic [NUM_IND-1:0]          sell_votes;
    logic [6:0]                  win_pct;
    logic                        out_valid;
    logic [1:0]                  out_action;
    logic [ID_W-1:0]             out_stock_id;
    logic [QTY_W-1:0]            out_qty;
    logic [CASH_W-1:0]           cash;
    logic signed [PROFIT_W-1:0]  profit;

    modport master (
        output in_valid, data_in, buy_votes, sell_votes, win_pct,
        input  in_ready, out_valid, out_action, out_stock_id, out_qty, cash, profit
    );

    modport slave (
        input  in_valid, data_in, buy_votes, sell_votes, win_pct,
        output in_ready, out_valid, out_action, out_stock_id, out_qty, cash, profit
    );
endinterface

// File: rtl/kelly_seq_div.sv
// Restoring divider by the constant 100, one quotient bit per cycle.
// The first bit is resolved on the start edge so done rises DW-1 cycles later.
module kelly_seq_div
    import kelly_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    output logic             done,
    output logic [QTY_W-1:0] quotient
);
    localparam int RW = 8;

    logic [RW-1:0]    rem;
    logic [DIV_W-1:0] q;
    logic [4:0]       cnt;
    logic             busy;

    // Dividend bits shift out of the top of q while quotient bits shift in at the bottom.
    function automatic logic [RW+DIV_W-1:0] div_step(input logic [RW-1:0] r,
                                                     input logic [DIV_W-1:0] d);
        logic [RW-1:0] trial;
        logic          ge;
        trial = {r[RW-2:0], d[DIV_W-1]};
        ge    = trial >= RW'(DIVISOR);
        return {(ge ? trial - RW'(DIVISOR) : trial), d[DIV_W-2:0], ge};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {rem, q} <= div_step('0, dividend);
                cnt      <= 5'(DIV_W - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                {rem, q} <= div_step(rem, q);
                cnt      <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = q[QTY_W-1:0];
endmodule

// File: rtl/kelly_portfolio.sv
// Multi-stock Kelly position sizer: sizes an order, commits it against shared cash, revalues the book.
// Define KELLY_PORTFOLIO_STATS_EN to add saturating trade_count / reject_count outputs.
module kelly_portfolio
    import kelly_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    kelly_portfolio_if.slave   bus,
    output state_t             dbg_state
`ifdef KELLY_PORTFOLIO_STATS_EN
    , output logic [15:0]      trade_count
    , output logic [15:0]      reject_count
`endif
);
    localparam logic [QTY_W:0]  QTY_MAX  = {1'b0, {QTY_W{1'b1}}};
    localparam logic [CASH_W:0] CASH_MAX = {1'b0, {CASH_W{1'b1}}};
    localparam logic [ID_W:0]   VAL_END  = (ID_W+1)'(NUM_STOCKS);
    localparam logic [ID_W:0]   VAL_LAST = (ID_W+1)'(NUM_STOCKS - 1);

    state_t               st;
    logic [QTY_W-1:0]     holdings   [NUM_STOCKS];
    logic [PRICE_W-1:0]   last_price [NUM_STOCKS];
    logic [ID_W-1:0]      cur_id;
    logic [PRICE_W-1:0]   cur_price;
    act_t                 side;
    act_t                 res_act;
    logic [ID_W:0]        val_idx;
    logic [PROFIT_W-1:0]  acc;

    logic [ID_W-1:0]      acc_id;
    logic [PRICE_W-1:0]   acc_price;
    logic                 accept;
    logic [DIV_W-1:0]     dividend;
    logic                 div_done;
    logic [QTY_W-1:0]     qty;

    assign acc_id    = bus.data_in[ID_W+PRICE_W-1:PRICE_W];
    assign acc_price = bus.data_in[PRICE_W-1:0];
    assign accept    = (st == S_IDLE) && bus.in_valid;
    assign dividend  = DIV_W'(holdings[acc_id]) * DIV_W'(kelly_kp(bus.win_pct));
    assign dbg_state = st;

    kelly_seq_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .dividend (dividend),
        .done     (div_done),
        .quotient (qty)
    );

    logic [CASH_W-1:0]   cost;
    logic [QTY_W:0]      buy_sum;
    logic [CASH_W:0]     sell_sum;
    act_t                commit_act;
    logic [CASH_W-1:0]   cash_new;
    logic [QTY_W-1:0]    hold_new;
    logic [PROFIT_W-1:0] term;
    logic [PROFIT_W-1:0] equity;

    // Commit decision; qty*price never exceeds CASH_W bits for these widths.
    always_comb begin
        cost       = CASH_W'(qty) * CASH_W'(cur_price);
        buy_sum    = {1'b0, holdings[cur_id]} + {1'b0, qty};
        sell_sum   = {1'b0, bus.cash} + {1'b0, cost};
        commit_act = ACT_HOLD;
        cash_new   = bus.cash;
        hold_new   = holdings[cur_id];
        if (side != ACT_HOLD && qty != '0) begin
            if (side == ACT_BUY) begin
                if (cost > bus.cash || buy_sum > QTY_MAX) begin
                    commit_act = ACT_REJECT;
                end else begin
                    commit_act = ACT_BUY;
                    cash_new   = bus.cash - cost;
                    hold_new   = holdings[cur_id] + qty;
                end
            end else begin
                if (holdings[cur_id] < qty || sell_sum > CASH_MAX) begin
                    commit_act = ACT_REJECT;
                end else begin
                    commit_act = ACT_SELL;
                    cash_new   = bus.cash + cost;
                    hold_new   = holdings[cur_id] - qty;
                end
            end
        end
    end

    always_comb begin
        term   = PROFIT_W'(holdings[val_idx[ID_W-1:0]]) * PROFIT_W'(last_price[val_idx[ID_W-1:0]]);
        equity = acc + term;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st               <= S_IDLE;
            bus.in_ready     <= 1'b1;
            bus.out_valid    <= 1'b0;
            bus.out_action   <= 2'd0;
            bus.out_stock_id <= '0;
            bus.out_qty      <= '0;
            bus.cash         <= CASH_W'(INIT_CASH);
            bus.profit       <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                holdings[i]   <= QTY_W'(INIT_SHARES);
                last_price[i] <= '0;
            end
            cur_id    <= '0;
            cur_price <= '0;
            side      <= ACT_HOLD;
            res_act   <= ACT_HOLD;
            val_idx   <= '0;
            acc       <= '0;
`ifdef KELLY_PORTFOLIO_STATS_EN
            trade_count  <= '0;
            reject_count <= '0;
`endif
        end else begin
            bus.out_valid <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        cur_id             <= acc_id;
                        cur_price          <= acc_price;
                        side               <= vote_side(bus.buy_votes, bus.sell_votes);
                        last_price[acc_id] <= acc_price;
                        bus.in_ready       <= 1'b0;
                        st                 <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (div_done) st <= S_COMMIT;
                end
                S_COMMIT: begin
                    res_act          <= commit_act;
                    bus.cash         <= cash_new;
                    holdings[cur_id] <= hold_new;
                    acc              <= PROFIT_W'(cash_new);
                    val_idx          <= '0;
                    st               <= S_VALUE;
`ifdef KELLY_PORTFOLIO_STATS_EN
                    if ((commit_act == ACT_BUY || commit_act == ACT_SELL) && trade_count != 16'hFFFF)
                        trade_count <= trade_count + 16'd1;
                    if (commit_act == ACT_REJECT && reject_count != 16'hFFFF)
                        reject_count <= reject_count + 16'd1;
`endif
                end
                S_VALUE: begin
                    // One extra pass after the last stock lets out_valid drop before in_ready returns.
                    if (val_idx == VAL_END) begin
                        bus.in_ready <= 1'b1;
                        st           <= S_IDLE;
                    end else begin
                        acc     <= equity;
                        val_idx <= val_idx + 1'b1;
                        if (val_idx == VAL_LAST) begin
                            bus.out_valid    <= 1'b1;
                            bus.out_action   <= res_act;
                            bus.out_stock_id <= cur_id;
                            bus.out_qty      <= qty;
                            bus.profit       <= $signed(equity - PROFIT_W'(INIT_CASH));
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kelly_portfolio.sv
// Directed bench for kelly_portfolio: expected results are queued at issue and popped by an output monitor.
module tb_kelly_portfolio;
    import kelly_pkg::*;

    localparam int EXP_W   = 2 + ID_W + QTY_W + CASH_W + PROFIT_W;
    localparam int LATENCY = 23;

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    always #5 clk = ~clk;

    kelly_portfolio_if bus();

`ifdef KELLY_PORTFOLIO_STATS_EN
    logic [15:0] trade_count;
    logic [15:0] reject_count;
`endif

    kelly_portfolio dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
`ifdef KELLY_PORTFOLIO_STATS_EN
        , .trade_count  (trade_count)
        , .reject_count (reject_count)
`endif
    );

    logic [EXP_W-1:0] exp_q[$];
    int n_checks   = 0;
    int n_pass     = 0;
    int cyc        = 0;
    int accept_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every result pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_action", int'(bus.out_action), int'(e[EXP_W-1 -: 2]));
                check("out_stock_id", int'(bus.out_stock_id), int'(e[EXP_W-3 -: ID_W]));
                check("out_qty", int'(bus.out_qty), int'(e[CASH_W+PROFIT_W +: QTY_W]));
                check("cash", int'(bus.cash), int'(e[PROFIT_W +: CASH_W]));
                check("profit", int'($signed(bus.profit)), int'($signed(e[PROFIT_W-1:0])));
                check("latency", cyc + 1 - accept_cyc, LATENCY);
            end
        end
    end

    task automatic do_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.data_in    = '0;
        bus.buy_votes  = '0;
        bus.sell_votes = '0;
        bus.win_pct    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [ID_W-1:0] id, input logic [PRICE_W-1:0] price,
                        input logic [NUM_IND-1:0] bv, input logic [NUM_IND-1:0] sv,
                        input logic [6:0] win, input bit push, input act_t ea,
                        input int eq, input int ecash, input int eprof);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        bus.in_valid   = 1'b1;
        bus.data_in    = {id, price};
        bus.buy_votes  = bv;
        bus.sell_votes = sv;
        bus.win_pct    = win;
        if (push) exp_q.push_back({ea, id, QTY_W'(eq), CASH_W'(ecash), PROFIT_W'(eprof)});
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result();
        bit seen_ready;
        bit got;
        seen_ready = 1'b0;
        got        = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.out_valid) got = 1'b1;
            else begin
                if (bus.in_ready) seen_ready = 1'b1;
                @(negedge clk);
            end
        end
        check("result_seen", int'(got), 1);
        check("in_ready_low_busy", int'(seen_ready), 0);
        @(negedge clk);
        check("out_valid_one_cycle", int'(bus.out_valid), 0);
        check("in_ready_after", int'(bus.in_ready), 1);
    endtask

    task automatic run(input logic [ID_W-1:0] id, input logic [PRICE_W-1:0] price,
                       input logic [NUM_IND-1:0] bv, input logic [NUM_IND-1:0] sv,
                       input logic [6:0] win, input act_t ea,
                       input int eq, input int ecash, input int eprof);
        send(id, price, bv, sv, win, 1'b1, ea, eq, ecash, eprof);
        wait_result();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        do_reset();
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_action", int'(bus.out_action), 0);
        check("rst_out_stock_id", int'(bus.out_stock_id), 0);
        check("rst_out_qty", int'(bus.out_qty), 0);
        check("rst_cash", int'(bus.cash), INIT_CASH);
        check("rst_profit", int'($signed(bus.profit)), 0);
        check("rst_state", int'(dbg_state), int'(S_IDLE));

        // kp 20 on 100 shares -> buy 20 at 10
        run(2'd0, 6'd10, 3'b110, 3'b000, 7'd60, ACT_BUY, 20, 24800, 1000);

        do_reset();
        // kp 50 -> sell 50 at 20
        run(2'd1, 6'd20, 3'b000, 3'b111, 7'd75, ACT_SELL, 50, 26000, 2000);

        do_reset();
        run(2'd0, 6'd10, 3'b111, 3'b000, 7'd50, ACT_HOLD, 0, 25000, 1000);
        run(2'd1, 6'd5, 3'b011, 3'b000, 7'd40, ACT_HOLD, 0, 25000, 1500);
        run(2'd2, 6'd1, 3'b110, 3'b011, 7'd50, ACT_HOLD, 0, 25000, 1600);

        do_reset();
        run(2'd2, 6'd63, 3'b111, 3'b000, 7'd100, ACT_BUY, 100, 18700, 6300);
        run(2'd2, 6'd63, 3'b111, 3'b000, 7'd100, ACT_BUY, 200, 6100, 6300);
        run(2'd2, 6'd63, 3'b111, 3'b000, 7'd100, ACT_REJECT, 400, 6100, 6300);

        do_reset();
        // win above 100 clamps to kp 100: sell all 100 shares at 1
        run(2'd3, 6'd1, 3'b000, 3'b101, 7'd127, ACT_SELL, 100, 25100, 100);

        // Abort mid-division: nothing may commit or emerge.
        do_reset();
        send(2'd3, 6'd50, 3'b111, 3'b000, 7'd100, 1'b0, ACT_HOLD, 0, 0, 0);
        repeat (4) @(negedge clk);
        check("abort_in_div", int'(dbg_state), int'(S_DIV));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_cash", int'(bus.cash), INIT_CASH);
        check("abort_state", int'(dbg_state), int'(S_IDLE));
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("abort_no_result", int'(seen_valid), 0);
        // Holdings back at 100 and last_price[3] cleared: profit only from stock 0.
        run(2'd0, 6'd10, 3'b110, 3'b000, 7'd60, ACT_BUY, 20, 24800, 1000);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
